// File: rtl/regfile_sb.sv
// Parametrised register file with issue scoreboard; 0-cycle reads, 1-cycle write/busy update.
// iss_ready_o drops on a pending destination or flush; REGFILE_BYPASS_EN enables same-cycle write-back forwarding.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_addr_i,
  output logic              iss_ready_o,
  input  logic              wb_valid_i,
  input  logic [AW-1:0]     wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic              flush_i,
  output logic [NREG-1:0]   busy_vec_o
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            iss_blocked;

  // Addresses beyond NREG exist only when AW is wider than log2(NREG).
  function automatic logic in_rng(input logic [AW-1:0] a);
    return int'(a) < NREG;
  endfunction

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] dat;
    logic            bsy;

    assign addr = rd_addr_i[k*AW +: AW];

    always_comb begin
      dat = '0;
      bsy = 1'b0;
      if (addr != '0 && in_rng(addr)) begin
        dat = regs[addr];
        bsy = busy[addr];
`ifdef REGFILE_BYPASS_EN
        if (wb_valid_i && wb_addr_i == addr) begin
          dat = wb_data_i;
          bsy = 1'b0;
        end
`endif
      end
    end

    assign rd_data_o[k*XLEN +: XLEN] = dat;
    assign rd_busy_o[k]              = bsy;
  end

  always_comb begin
    iss_blocked = 1'b0;
    if (iss_addr_i != '0 && in_rng(iss_addr_i)) begin
      iss_blocked = busy[iss_addr_i];
`ifdef REGFILE_BYPASS_EN
      // A write-back landing this cycle releases the destination for a new producer.
      if (wb_valid_i && wb_addr_i == iss_addr_i) iss_blocked = 1'b0;
`endif
    end
  end

  assign iss_ready_o = !flush_i && !iss_blocked;

  // Flush beats issue; an issue's set beats a same-register write-back clear.
  always_comb begin
    busy_nxt = busy;
    if (flush_i) begin
      busy_nxt = '0;
    end else begin
      if (wb_valid_i && in_rng(wb_addr_i)) busy_nxt[wb_addr_i] = 1'b0;
      if (iss_valid_i && iss_ready_o && iss_addr_i != '0 && in_rng(iss_addr_i))
        busy_nxt[iss_addr_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (wb_valid_i && wb_addr_i != '0 && in_rng(wb_addr_i)) begin
      regs[wb_addr_i] <= wb_data_i;
    end
  end

  assign busy_vec_o = busy;

endmodule
